uart_tx_phy: RTL

- Serial transmitter that consumes the byte stream produced by the memory-mapped UART register block (tx_data/tx_valid, backpressured by tx_ready) and drives the 8N1 TXD line.
- A small synchronous FIFO decouples single-cycle register writes from the bit-serial shifter.
- Sits between the SoC-side UART register block and the board pin.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_tx_phy_if.sv | 12 +
 rtl/uart_tx_fifo.sv | 57 +++++
 rtl/uart_tx_phy.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types, framing constants and the baud divider helper for the UART transmit path.
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;

   localparam int unsigned UART_DATA_BITS = 8;
   localparam int unsigned UART_STOP_BITS = 1;

   function automatic int unsigned uart_div(input int unsigned clk_hz, input int unsigned baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_tx_phy_if.sv
// Byte push handshake between the UART register block and the transmit PHY.
interface uart_tx_phy_if;
   import uart_pkg::*;

   logic [UART_DATA_BITS-1:0] tx_data;
   logic                      tx_valid;
   logic                      tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous power-of-two FIFO; dout shows the head entry combinationally while not empty.
module uart_tx_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [WIDTH-1:0]       din,
   input  logic                   pop,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned AW = $clog2(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_fifo: DEPTH must be a power of two and at least 2");
   end

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, rd_q;
   logic [AW:0]      cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign count   = cnt_q;
   assign dout    = mem_q[rd_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      cnt_d = cnt_q;
      if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
      else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_phy.sv
// 8N1 serial transmitter fed from a byte FIFO; define UART_TX_PARITY_EN for an even-parity bit.
module uart_tx_phy
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 50000000,
   parameter int unsigned BAUD_RATE  = 115200,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   uart_tx_phy_if.slave                tx_if,
   output logic                        txd,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   localparam int unsigned DIV = uart_div(CLK_FREQ, BAUD_RATE);
   localparam int unsigned CW  = (DIV < 2) ? 1 : $clog2(DIV);
   localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

   if (DIV < 2) begin : g_bad_div
      $error("uart_tx_phy: CLK_FREQ/BAUD_RATE must be at least 2");
   end

   uart_tx_state_t      state_q, state_d;
   logic [CW-1:0]       baud_q, baud_d;
   logic [2:0]          bit_q, bit_d;
   logic [UART_DATA_BITS:0] shift_q, shift_d;
   logic                txd_q, txd_d;
   logic                pop, bit_done;
   logic                fifo_full, fifo_empty;
   logic [UART_DATA_BITS-1:0] fifo_dout;

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (UART_DATA_BITS)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_if.tx_valid),
      .din   (tx_if.tx_data),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign tx_if.tx_ready = !fifo_full;
   assign txd            = txd_q;
   assign busy           = (state_q != IDLE) || (fifo_count != '0);
   assign bit_done       = (baud_q == BAUD_LAST);

   // Parity rides above the data in shift[8]; after the seventh shift it sits at shift[1].
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      txd_d   = txd_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            baud_d = '0;
            txd_d  = 1'b1;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = {^fifo_dout, fifo_dout};
               state_d = START;
               txd_d   = 1'b0;
            end
         end
         START: begin
            if (bit_done) begin
               state_d = DATA;
               baud_d  = '0;
               bit_d   = '0;
               txd_d   = shift_q[0];
            end
         end
         DATA: begin
            if (bit_done) begin
               baud_d  = '0;
               shift_d = shift_q >> 1;
               if (bit_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
                  txd_d   = shift_q[1];
`else
                  state_d = STOP;
                  txd_d   = 1'b1;
`endif
               end else begin
                  bit_d = bit_q + 1'b1;
                  txd_d = shift_q[1];
               end
            end
         end
         PARITY: begin
`ifdef UART_TX_PARITY_EN
            if (bit_done) begin
               state_d = STOP;
               baud_d  = '0;
               txd_d   = 1'b1;
            end
`else
            state_d = IDLE;
            baud_d  = '0;
            txd_d   = 1'b1;
`endif
         end
         STOP: begin
            if (bit_done) begin
               baud_d = '0;
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_d = {^fifo_dout, fifo_dout};
                  state_d = START;
                  txd_d   = 1'b0;
               end else begin
                  state_d = IDLE;
                  txd_d   = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            baud_d  = '0;
            txd_d   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         txd_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         txd_q   <= txd_d;
      end
   end

endmodule
